// File: rtl/life_pkg.sv
// Shared types, rule constants and neighbour addressing for the Game of Life engine.
// Optional stable-board detection in life_engine is enabled by LIFE_STABLE_DETECT_EN.
package life_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    SWAP    = 2'd2
  } life_state_e;

  localparam int RULE_SURVIVE_MIN = 2;
  localparam int RULE_SURVIVE_MAX = 3;
  localparam int RULE_BIRTH       = 3;
  localparam int GEN_CNT_W        = 16;

  // Neighbour offsets in a fixed order: NW, N, NE, W, E, SW, S, SE.
  localparam int NBR_DR [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
  localparam int NBR_DC [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } nbr_t;

  // Address of the cell at (row+drow, col+dcol); invalid when it falls off a non-wrapping board.
  function automatic nbr_t nbr_addr(input int row, input int col, input int drow, input int dcol,
                                    input int w_bits, input int h_bits, input logic wrap);
    int   r;
    int   c;
    int   rows;
    int   cols;
    nbr_t res;
    rows = 1 << h_bits;
    cols = 1 << w_bits;
    r    = row + drow;
    c    = col + dcol;
    if (wrap) begin
      r         = r & (rows - 1);
      c         = c & (cols - 1);
      res.valid = 1'b1;
    end else begin
      res.valid = (r >= 0) && (r < rows) && (c >= 0) && (c < cols);
    end
    if (res.valid) begin
      res.addr = 32'(r * cols + c);
    end else begin
      res.addr = 32'd0;
    end
    return res;
  endfunction

endpackage

// File: rtl/life_cell_rule.sv
// Conway rule for one cell: next state from the centre bit and its eight neighbours.
module life_cell_rule
  import life_pkg::*;
(
  input  logic [7:0] i_nbrs,
  input  logic       i_centre,
  output logic       o_next
);

  logic [3:0] w_cnt;
  logic       w_next;

  // Population count and survive/birth decision.
  always_comb begin
    w_cnt = 4'd0;
    for (int k = 0; k < 8; k++) begin
      w_cnt = w_cnt + {3'd0, i_nbrs[k]};
    end
    if (i_centre) begin
      w_next = (w_cnt >= 4'(RULE_SURVIVE_MIN)) && (w_cnt <= 4'(RULE_SURVIVE_MAX));
    end else begin
      w_next = (w_cnt == 4'(RULE_BIRTH));
    end
  end

  assign o_next = w_next;

endmodule

// File: rtl/life_engine.sv
// Double-buffered Game of Life core: one cell per cycle into the back bank, then a bank swap.
// Define LIFE_STABLE_DETECT_EN to build the stable-generation detector.
module life_engine
  import life_pkg::*;
#(
  parameter int W_BITS = 3,
  parameter int H_BITS = 3,
  parameter int WRAP   = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       step_req,
  input  logic                       wr_en,
  input  logic [W_BITS+H_BITS-1:0]   wr_addr,
  input  logic                       wr_data,
  input  logic [W_BITS+H_BITS-1:0]   rd_addr,
  output logic                       rd_data,
  output logic                       busy,
  output logic                       gen_done,
  output logic [GEN_CNT_W-1:0]       gen_count,
  output logic                       stable
);

  localparam int AW = W_BITS + H_BITS;
  localparam int N  = 2 ** AW;

  life_state_e          r_state;
  life_state_e          w_state_nxt;
  logic [N-1:0]         r_bank0;
  logic [N-1:0]         r_bank1;
  logic                 r_bank_sel;
  logic [AW-1:0]        r_idx;
  logic                 r_rd_data;
  logic                 r_busy;
  logic                 r_gen_done;
  logic [GEN_CNT_W-1:0] r_gen_count;

  logic [N-1:0]         w_front;
  logic [H_BITS-1:0]    w_row;
  logic [W_BITS-1:0]    w_col;
  nbr_t                 w_nb [8];
  logic [7:0]           w_nbrs;
  logic                 w_next;
  logic                 w_unused;

  assign w_front = r_bank_sel ? r_bank1 : r_bank0;
  assign w_row   = r_idx[AW-1:W_BITS];
  assign w_col   = r_idx[W_BITS-1:0];

  // Gather the eight front-bank neighbours of the cell being computed.
  always_comb begin
    w_unused = 1'b0;
    for (int k = 0; k < 8; k++) begin
      w_nb[k]   = nbr_addr(int'(w_row), int'(w_col), NBR_DR[k], NBR_DC[k],
                           W_BITS, H_BITS, WRAP != 0);
      w_nbrs[k] = w_nb[k].valid ? w_front[w_nb[k].addr[AW-1:0]] : 1'b0;
      w_unused  = w_unused ^ (^w_nb[k].addr[31:AW]);
    end
  end

  life_cell_rule u_rule (
    .i_nbrs   (w_nbrs),
    .i_centre (w_front[r_idx]),
    .o_next   (w_next)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (step_req) begin
          w_state_nxt = COMPUTE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      COMPUTE: begin
        if (r_idx == AW'(N - 1)) begin
          w_state_nxt = SWAP;
        end else begin
          w_state_nxt = COMPUTE;
        end
      end
      SWAP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Banks, scan index, generation counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank0     <= '0;
      r_bank1     <= '0;
      r_bank_sel  <= 1'b0;
      r_idx       <= '0;
      r_rd_data   <= 1'b0;
      r_busy      <= 1'b0;
      r_gen_done  <= 1'b0;
      r_gen_count <= '0;
    end else begin
      r_rd_data  <= w_front[rd_addr];
      r_busy     <= (w_state_nxt != IDLE);
      r_gen_done <= (r_state == SWAP);
      case (r_state)
        IDLE: begin
          r_idx <= '0;
          if (wr_en) begin
            if (r_bank_sel) begin
              r_bank1[wr_addr] <= wr_data;
            end else begin
              r_bank0[wr_addr] <= wr_data;
            end
          end
        end
        COMPUTE: begin
          if (r_bank_sel) begin
            r_bank0[r_idx] <= w_next;
          end else begin
            r_bank1[r_idx] <= w_next;
          end
          r_idx <= r_idx + AW'(1);
        end
        SWAP: begin
          r_bank_sel  <= ~r_bank_sel;
          r_gen_count <= r_gen_count + GEN_CNT_W'(1);
        end
        default: r_idx <= '0;
      endcase
    end
  end

`ifdef LIFE_STABLE_DETECT_EN
  logic r_changed;
  logic r_stable;

  // Sticky change flag over one generation, latched into stable at the swap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_changed <= 1'b0;
      r_stable  <= 1'b0;
    end else begin
      case (r_state)
        IDLE:    r_changed <= 1'b0;
        COMPUTE: r_changed <= r_changed | (w_next != w_front[r_idx]);
        SWAP:    r_stable  <= ~r_changed;
        default: r_changed <= 1'b0;
      endcase
    end
  end

  assign stable = r_stable;
`else
  assign stable = 1'b0;
`endif

  assign rd_data   = r_rd_data;
  assign busy      = r_busy;
  assign gen_done  = r_gen_done;
  assign gen_count = r_gen_count;

endmodule

// File: tb/tb_life_engine.sv
// Self-checking bench for life_engine: a dead-border and a toroidal instance share stimulus
// and are compared against a cell-by-cell Game of Life model.
module tb_life_engine;

  localparam int ROWS = 8;
  localparam int COLS = 8;

  logic        clk;
  logic        rst_n;
  logic        step_req;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic        wr_data;
  logic [5:0]  rd_addr;
  logic        rd0, rd1, busy0, busy1, done0, done1, stable0, stable1;
  logic [15:0] gc0, gc1;

  bit m0 [64];
  bit m1 [64];
  bit d0 [64];
  bit d1 [64];
  bit exp_st0, exp_st1;
  int exp_gen;
  int checks;
  int failures;

  life_engine #(.W_BITS(3), .H_BITS(3), .WRAP(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .step_req(step_req), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd0), .busy(busy0), .gen_done(done0),
    .gen_count(gc0), .stable(stable0)
  );

  life_engine #(.W_BITS(3), .H_BITS(3), .WRAP(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .step_req(step_req), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd1), .busy(busy1), .gen_done(done1),
    .gen_count(gc1), .stable(stable1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_board();
    for (int i = 0; i < 64; i++) begin
      rd_addr = 6'(i);
      tick();
      d0[i] = rd0;
      d1[i] = rd1;
    end
  endtask

  task automatic write_cell(input int a, input bit v);
    wr_en   = 1'b1;
    wr_addr = 6'(a);
    wr_data = v;
    tick();
    wr_en = 1'b0;
    m0[a] = v;
    m1[a] = v;
  endtask

  task automatic clear_board();
    for (int i = 0; i < 64; i++) write_cell(i, 1'b0);
  endtask

  function automatic bit alive_at(input bit wrap, input int r, input int c);
    int rr;
    int cc;
    if (wrap) begin
      rr = (r + ROWS) % ROWS;
      cc = (c + COLS) % COLS;
      return m1[rr * COLS + cc];
    end
    if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return 1'b0;
    return m0[r * COLS + c];
  endfunction

  task automatic model_step();
    bit n0 [64];
    bit n1 [64];
    for (int w = 0; w < 2; w++) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          int cnt;
          bit cur;
          bit nxt;
          cnt = 0;
          for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
              if (dr != 0 || dc != 0) cnt += int'(alive_at(w == 1, r + dr, c + dc));
          cur = (w == 1) ? m1[r * COLS + c] : m0[r * COLS + c];
          nxt = cur ? (cnt == 2 || cnt == 3) : (cnt == 3);
          if (w == 1) n1[r * COLS + c] = nxt;
          else n0[r * COLS + c] = nxt;
        end
      end
    end
    exp_st0 = 1'b1;
    exp_st1 = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (n0[i] != m0[i]) exp_st0 = 1'b0;
      if (n1[i] != m1[i]) exp_st1 = 1'b0;
      m0[i] = n0[i];
      m1[i] = n1[i];
    end
`ifndef LIFE_STABLE_DETECT_EN
    exp_st0 = 1'b0;
    exp_st1 = 1'b0;
`endif
    exp_gen = (exp_gen + 1) % 65536;
  endtask

  // One generation over a fixed observation window; optional write with the request and a
  // collision (step_req + write of 1 to cell 0) at window sample collide_at.
  task automatic run_step(input int collide_at, input bit wr_on, input int wa, input bit wd,
                          output int b0, output int b1, output int dn);
    wr_en    = wr_on;
    wr_addr  = 6'(wa);
    wr_data  = wd;
    step_req = 1'b1;
    if (wr_on) begin
      m0[wa] = wd;
      m1[wa] = wd;
    end
    tick();
    step_req = 1'b0;
    wr_en    = 1'b0;
    b0 = 0; b1 = 0; dn = 0;
    for (int c = 0; c < 70; c++) begin
      if (busy0) b0++;
      if (busy1) b1++;
      if (done0) dn++;
      if (c == collide_at) begin
        step_req = 1'b1; wr_en = 1'b1; wr_addr = 6'd0; wr_data = 1'b1;
      end else begin
        step_req = 1'b0; wr_en = 1'b0;
      end
      tick();
    end
    step_req = 1'b0;
    wr_en    = 1'b0;
    model_step();
  endtask

  task automatic test_reset();
    read_board();
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (d0[i] !== 1'b0 || d1[i] !== 1'b0) begin
        $display("FAIL reset_cell[%0d] got %b/%b want 0", i, d0[i], d1[i]); failures++;
      end
    end
    checks++;
    if (busy0 !== 1'b0 || gc0 !== 16'd0 || done0 !== 1'b0 || stable0 !== 1'b0) begin
      $display("FAIL reset_outs busy=%b gc=%0d done=%b stable=%b want 0", busy0, gc0, done0, stable0);
      failures++;
    end
  endtask

  task automatic test_blinker();
    int b0, b1, dn;
    bit e [64];
    write_cell(27, 1'b1); write_cell(28, 1'b1); write_cell(29, 1'b1);
    run_step(-1, 1'b0, 0, 1'b0, b0, b1, dn);
    checks++;
    if (b0 != 65 || b1 != 65) begin
      $display("FAIL blinker_busy got %0d/%0d want 65", b0, b1); failures++;
    end
    checks++;
    if (dn != 1) begin $display("FAIL blinker_done got %0d pulses want 1", dn); failures++; end
    checks++;
    if (gc0 !== 16'd1) begin $display("FAIL blinker_gc got %0d want 1", gc0); failures++; end
    read_board();
    foreach (e[i]) e[i] = (i == 20 || i == 28 || i == 36);
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (d0[i] !== e[i] || d1[i] !== e[i]) begin
        $display("FAIL blinker_gen1[%0d] got %b/%b want %b", i, d0[i], d1[i], e[i]); failures++;
      end
    end
    run_step(-1, 1'b0, 0, 1'b0, b0, b1, dn);
    read_board();
    foreach (e[i]) e[i] = (i == 27 || i == 28 || i == 29);
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (d0[i] !== e[i] || d1[i] !== e[i]) begin
        $display("FAIL blinker_gen2[%0d] got %b/%b want %b", i, d0[i], d1[i], e[i]); failures++;
      end
    end
    checks++;
    if (gc1 !== 16'(exp_gen)) begin $display("FAIL blinker_gc2 got %0d want %0d", gc1, exp_gen); failures++; end
  endtask

  task automatic test_edge();
    int b0, b1, dn;
    clear_board();
    write_cell(0, 1'b1); write_cell(8, 1'b1); write_cell(16, 1'b1);
    run_step(-1, 1'b0, 0, 1'b0, b0, b1, dn);
    read_board();
    for (int i = 0; i < 64; i++) begin
      bit e0, e1;
      e0 = (i == 8 || i == 9);
      e1 = (i == 8 || i == 9 || i == 15);
      checks++;
      if (d0[i] !== e0 || d1[i] !== e1) begin
        $display("FAIL edge_gen1[%0d] got %b/%b want %b/%b", i, d0[i], d1[i], e0, e1); failures++;
      end
    end
    run_step(-1, 1'b0, 0, 1'b0, b0, b1, dn);
    read_board();
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (d0[i] !== 1'b0 || d1[i] !== m1[i]) begin
        $display("FAIL edge_gen2[%0d] got %b/%b want 0/%b", i, d0[i], d1[i], m1[i]); failures++;
      end
    end
  endtask

  task automatic test_random();
    int b0, b1, dn;
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 64; i++) write_cell(i, $urandom_range(0, 2) == 0);
      run_step(-1, it[0], $urandom_range(0, 63), 1'b1, b0, b1, dn);
      if (it == 3) run_step(-1, 1'b0, 0, 1'b0, b0, b1, dn);
      read_board();
      for (int i = 0; i < 64; i++) begin
        checks++;
        if (d0[i] !== m0[i] || d1[i] !== m1[i]) begin
          $display("FAIL random%0d[%0d] got %b/%b want %b/%b", it, i, d0[i], d1[i], m0[i], m1[i]);
          failures++;
        end
      end
      checks++;
      if (stable0 !== exp_st0 || stable1 !== exp_st1 || gc0 !== 16'(exp_gen) || dn != 1) begin
        $display("FAIL random%0d_status stable=%b/%b gc=%0d done=%0d want %b/%b %0d 1",
                 it, stable0, stable1, gc0, dn, exp_st0, exp_st1, exp_gen);
        failures++;
      end
    end
  endtask

  task automatic test_busy_collision();
    int b0, b1, dn;
    for (int i = 0; i < 64; i++) write_cell(i, $urandom_range(0, 1) == 1);
    write_cell(0, 1'b0);
    run_step(20, 1'b0, 0, 1'b0, b0, b1, dn);
    checks++;
    if (b0 != 65 || dn != 1 || gc0 !== 16'(exp_gen)) begin
      $display("FAIL collision_status busy=%0d done=%0d gc=%0d want 65 1 %0d", b0, dn, gc0, exp_gen);
      failures++;
    end
    tick();
    checks++;
    if (busy0 !== 1'b0) begin $display("FAIL collision_queued busy=%b want 0", busy0); failures++; end
    read_board();
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (d0[i] !== m0[i] || d1[i] !== m1[i]) begin
        $display("FAIL collision_cell[%0d] got %b/%b want %b/%b", i, d0[i], d1[i], m0[i], m1[i]);
        failures++;
      end
    end
  endtask

  task automatic test_stable();
    int b0, b1, dn;
    bit want;
    clear_board();
    write_cell(18, 1'b1); write_cell(19, 1'b1); write_cell(26, 1'b1); write_cell(27, 1'b1);
    run_step(-1, 1'b0, 0, 1'b0, b0, b1, dn);
    read_board();
    for (int i = 0; i < 64; i++) begin
      bit e;
      e = (i == 18 || i == 19 || i == 26 || i == 27);
      checks++;
      if (d0[i] !== e || d1[i] !== e) begin
        $display("FAIL block_cell[%0d] got %b/%b want %b", i, d0[i], d1[i], e); failures++;
      end
    end
`ifdef LIFE_STABLE_DETECT_EN
    want = 1'b1;
`else
    want = 1'b0;
`endif
    checks++;
    if (stable0 !== want || stable1 !== want) begin
      $display("FAIL block_stable got %b/%b want %b", stable0, stable1, want); failures++;
    end
    clear_board();
    write_cell(27, 1'b1); write_cell(28, 1'b1); write_cell(29, 1'b1);
    run_step(-1, 1'b0, 0, 1'b0, b0, b1, dn);
    checks++;
    if (stable0 !== 1'b0 || stable1 !== 1'b0) begin
      $display("FAIL blinker_stable got %b/%b want 0", stable0, stable1); failures++;
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 64; i++) write_cell(i, $urandom_range(0, 1) == 1);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    repeat (30) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0 || gc0 !== 16'd0 || gc1 !== 16'd0 || stable0 !== 1'b0) begin
      $display("FAIL async_reset_outs busy=%b/%b gc=%0d/%0d stable=%b want 0",
               busy0, busy1, gc0, gc1, stable0);
      failures++;
    end
    #3 rst_n = 1'b1;
    foreach (m0[i]) begin m0[i] = 1'b0; m1[i] = 1'b0; end
    exp_gen = 0;
    tick();
    checks++;
    if (busy0 !== 1'b0) begin $display("FAIL async_reset_idle busy=%b want 0", busy0); failures++; end
    read_board();
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (d0[i] !== 1'b0 || d1[i] !== 1'b0) begin
        $display("FAIL async_reset_cell[%0d] got %b/%b want 0", i, d0[i], d1[i]); failures++;
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_gen  = 0;
    exp_st0  = 1'b0;
    exp_st1  = 1'b0;
    foreach (m0[i]) begin m0[i] = 1'b0; m1[i] = 1'b0; end
    rst_n    = 1'b0;
    step_req = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = 6'd0;
    wr_data  = 1'b0;
    rd_addr  = 6'd0;
    #12 rst_n = 1'b1;
    tick();
    test_reset();
    test_blinker();
    test_edge();
    test_random();
    test_busy_collision();
    test_stable();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
